cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling controller that sits directly upstream of the cache data array.
- On a cache miss it latches the miss address and the victim way. It then issues 8 consecutive word reads to the pipelined main memory.
- Each returning word is steered into the data array with the correct word offset and way select, together with the write strobe.
- After the last word it pulses a tag-array write and a completion strobe, which release the stalled pipeline.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, word width (matches data array data_in)
WORDS, 8, words per block; OFFSET_W = log2(WORDS) = 3, derived constant

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
miss_detected  input  1  level; cache lookup missed this cycle
miss_address  input  ADDR_W  byte address of the missing access
victim_way  input  1  way chosen for replacement (0/1)
mem_data  input  DATA_W  word returned by memory
mem_data_valid  input  1  mem_data valid this cycle
fsm_busy  output  1  high while a fill is in progress (pipeline stall)
mem_en  output  1  memory read request this cycle
mem_addr  output  ADDR_W  read request address
write_data_array  output  1  data array write enable (drives we)
data_offset  output  OFFSET_W  word offset for the data array write
data_way  output  1  way select for the data array write
data_out  output  DATA_W  write data to the data array (= mem_data, combinational)
write_tag_array  output  1  one-cycle tag/valid write strobe
fill_done  output  1  one-cycle completion strobe

Behaviour:
- Reset (async, rst_n=0): state=IDLE; issue_cnt=0, recv_cnt=0; latched address/way cleared. All outputs 0 except data_out, which follows mem_data.
- Reset asserted mid-fill aborts immediately. Words already written stay in the array; the tag is never written, so the line remains invalid.
- States: IDLE, FILL, DONE.
- IDLE:
  - On a clk edge with miss_detected=1, latch blk_addr = miss_address[ADDR_W-1:4] and way = victim_way, clear both counters, and go to FILL.
  - mem_data_valid in IDLE is ignored.
- FILL, request side:
  - While issue_cnt < 8: mem_en=1, mem_addr = {blk_addr, issue_cnt[2:0], 1'b0}, issue_cnt increments.
  - After 8 requests, mem_en=0.
  - Requests are issued back-to-back, one per cycle, with no dependence on returns.
- FILL, return side:
  - When mem_data_valid=1: write_data_array=1, data_offset=recv_cnt, data_way=way, and recv_cnt increments.
  - Words return in request order; the data array captures on the same edge.
- FILL exit: when mem_data_valid=1 and recv_cnt==7, that write completes and the next state is DONE.
- DONE: write_tag_array=1, fill_done=1 for exactly one cycle, then IDLE.
- fsm_busy = (state != IDLE), which includes DONE.
- miss_detected while busy: ignored. Re-asserting it in the cycle after DONE starts a new fill.
- Counters: 4-bit issue_cnt saturates at 8. recv_cnt is 3-bit and wraps to 0 on the 8th word (harmless, since the state leaves FILL).
- Latency: with memory latency L, the accept edge is cycle 0. Requests go out in cycles 1..8, returns arrive in cycles L+1..L+8, and DONE is cycle L+9.
- Outside FILL, write_data_array=0 and data_offset/data_way hold 0.

Decomposition:
- Shared cache package: OFFSET_W, the WORDS constant, and a state enum (IDLE=2'b00, FILL=2'b01, DONE=2'b10).
- Sub-module: cache_fill_counter, a reusable enabled counter with synchronous clear and async active-low reset, instanced for issue_cnt and recv_cnt. State and latch registers use the existing dff_16bit/dff-style flops.

Test Plan:
- Basic fill, memory model L=4: miss_address=0x1234, victim_way=1.
  - Requires mem_addr 0x1230,0x1232,…,0x123E in cycles 1..8.
  - Writes at cycles 5..12 with data_offset 0..7, data_way=1.
  - write_tag_array/fill_done high only at cycle 13; fsm_busy high cycles 1..13.
- Way 0 into data array model: fill 0xA0F0 with way 0, data words 0x1000+i; then read back via data_out0 for offsets 0..7 → values 0x1000..0x1007; way 1 contents unchanged.
- Busy lockout: hold miss_detected=1 for the whole fill with miss_address changing to 0xBEEF at cycle 3 → all mem_addr remain in block 0x1230; second fill starts only after fill_done.
- Spurious valid: pulse mem_data_valid with 0xDEAD in IDLE → write_data_array stays 0, no state change.
- Mid-fill reset: drop rst_n at cycle 7 of a fill → all outputs 0 asynchronously, state IDLE, no write_tag_array/fill_done; next miss fills normally.
- Back-to-back misses: new miss asserted in the cycle after DONE for 0x2000 → clean second fill of 0x2000..0x200E, exactly one fill_done per fill.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared constants, state encoding and address helper for the line-fill controller
package cache_fill_fsm_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int WORDS    = 8;
  localparam int OFFSET_W = $clog2(WORDS);
  // Block number is the byte address minus word offset and the byte-in-word bit.
  localparam int BLK_W    = ADDR_W - OFFSET_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    DONE = 2'b10
  } fill_state_e;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [BLK_W-1:0]    blk,
                                                  input logic [OFFSET_W-1:0] off);
    return {blk, off, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss, memory and data/tag array signals of the line-fill controller
interface cache_fill_fsm_if;
  import cache_fill_fsm_pkg::*;

  logic                miss_detected;
  logic [ADDR_W-1:0]   miss_address;
  logic                victim_way;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_data_valid;
  logic                fsm_busy;
  logic                mem_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic                write_data_array;
  logic [OFFSET_W-1:0] data_offset;
  logic                data_way;
  logic [DATA_W-1:0]   data_out;
  logic                write_tag_array;
  logic                fill_done;

  modport master (
    output miss_detected, miss_address, victim_way, mem_data, mem_data_valid,
    input  fsm_busy, mem_en, mem_addr, write_data_array, data_offset, data_way,
           data_out, write_tag_array, fill_done
  );

  modport slave (
    input  miss_detected, miss_address, victim_way, mem_data, mem_data_valid,
    output fsm_busy, mem_en, mem_addr, write_data_array, data_offset, data_way,
           data_out, write_tag_array, fill_done
  );

endinterface

// File: rtl/cache_fill_counter.sv
// rtl/cache_fill_counter.sv - enabled up-counter with synchronous clear and optional saturation
module cache_fill_counter #(
  parameter int          W        = 4,
  parameter bit          SATURATE = 1'b0,
  parameter logic [W-1:0] MAX     = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = SATURATE && (count == MAX);

  // Clear wins over enable so a new fill always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss line-fill controller: issues block reads and steers returns into the data array
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cache_fill_fsm_if.slave bus
);

  fill_state_e         state;
  logic [BLK_W-1:0]    blk_addr;
  logic                way;
  logic [OFFSET_W:0]   issue_cnt;
  logic [OFFSET_W-1:0] recv_cnt;

  logic accept;
  logic issuing;
  logic receiving;
  logic last_word;
  logic unused_addr_bits;

  assign accept    = (state == IDLE) && bus.miss_detected;
  assign issuing   = (state == FILL) && !issue_cnt[OFFSET_W];
  assign receiving = (state == FILL) && bus.mem_data_valid;
  assign last_word = receiving && (recv_cnt == OFFSET_W'(WORDS - 1));

  // Word and byte offset bits of the miss address select nothing: the whole block is fetched.
  assign unused_addr_bits = ^bus.miss_address[OFFSET_W:0];

  cache_fill_counter #(
    .W        (OFFSET_W + 1),
    .SATURATE (1'b1),
    .MAX      ((OFFSET_W + 1)'(WORDS))
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (issuing),
    .count (issue_cnt)
  );

  // Wraps to zero on the last word; harmless because the state leaves FILL on that edge.
  cache_fill_counter #(
    .W        (OFFSET_W),
    .SATURATE (1'b0),
    .MAX      ('1)
  ) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (receiving),
    .count (recv_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      blk_addr <= '0;
      way      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            blk_addr <= bus.miss_address[ADDR_W-1:OFFSET_W+1];
            way      <= bus.victim_way;
            state    <= FILL;
          end
        end
        FILL: begin
          if (last_word) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fsm_busy         = (state != IDLE);
  assign bus.mem_en           = issuing;
  assign bus.mem_addr         = issuing ? word_addr(blk_addr, issue_cnt[OFFSET_W-1:0]) : '0;
  assign bus.write_data_array = receiving;
  assign bus.data_offset      = receiving ? recv_cnt : '0;
  assign bus.data_way         = receiving & way;
  assign bus.data_out         = bus.mem_data;
  assign bus.write_tag_array  = (state == DONE);
  assign bus.fill_done        = (state == DONE);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm with a pipelined memory and data array model
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [15:0] d;
  } ret_t;

  ret_t        rq[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 4;
  int          flat = 4;
  int          acc = 0;
  bit          fill_valid = 1'b0;
  bit          seq_mode = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [11:0] fblk = '0;
  logic        fway = 1'b0;
  logic [15:0] arr     [2][8];
  logic [15:0] exp_arr [2][8];

  // Memory contents as a pure function of the word address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (seq_mode) return 16'h1000 + 16'(a[3:1]);
    return seed ^ (a * 16'h9E37) ^ {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.fsm_busy), 32'd0);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_wr"}, 32'(bus.write_data_array), 32'd0);
    chk({tag, "_offset"}, 32'(bus.data_offset), 32'd0);
    chk({tag, "_way"}, 32'(bus.data_way), 32'd0);
    chk({tag, "_tag"}, 32'(bus.write_tag_array), 32'd0);
    chk({tag, "_done"}, 32'(bus.fill_done), 32'd0);
    chk({tag, "_data_out"}, 32'(bus.data_out), 32'(bus.mem_data));
  endtask

  // One clock cycle: drive inputs, check outputs against the fill timeline, advance the models.
  task automatic step(input logic miss, input logic [15:0] maddr, input logic vway, input logic spur);
    bit          in_fill, exp_busy, exp_en, exp_wr, exp_done, idle;
    logic [2:0]  off;
    logic [15:0] exp_d;
    ret_t        r;
    @(negedge clk);
    bus.miss_detected = miss;
    bus.miss_address  = maddr;
    bus.victim_way    = vway;
    if (spur) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 16'hDEAD;
    end else if (rq.size() > 0 && rq[0].due == cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = rq[0].d;
      void'(rq.pop_front());
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data       = 16'($urandom);
    end
    #1;
    exp_busy = fill_valid && cyc > acc && cyc <= acc + flat + 9;
    in_fill  = fill_valid && cyc > acc && cyc <= acc + flat + 8;
    exp_en   = fill_valid && cyc > acc && cyc <= acc + 8;
    exp_wr   = fill_valid && cyc >= acc + flat + 1 && cyc <= acc + flat + 8;
    exp_done = fill_valid && cyc == acc + flat + 9;
    off      = 3'(cyc - acc - flat - 1);
    exp_d    = mem_word({fblk, off, 1'b0});

    chk("busy", 32'(bus.fsm_busy), 32'(exp_busy));
    chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
    if (exp_en) chk("mem_addr", 32'(bus.mem_addr), 32'({fblk, 3'(cyc - acc - 1), 1'b0}));
    chk("write_data_array", 32'(bus.write_data_array), 32'(exp_wr));
    if (exp_wr) begin
      chk("data_offset", 32'(bus.data_offset), 32'(off));
      chk("data_way", 32'(bus.data_way), 32'(fway));
      chk("data_out", 32'(bus.data_out), 32'(exp_d));
    end else if (!in_fill) begin
      chk("idle_offset", 32'(bus.data_offset), 32'd0);
      chk("idle_way", 32'(bus.data_way), 32'd0);
    end
    chk("write_tag_array", 32'(bus.write_tag_array), 32'(exp_done));
    chk("fill_done", 32'(bus.fill_done), 32'(exp_done));

    if (bus.mem_en) begin
      r.due = cyc + flat;
      r.d   = mem_word(bus.mem_addr);
      rq.push_back(r);
    end
    if (bus.write_data_array) arr[bus.data_way][bus.data_offset] = bus.data_out;
    if (exp_wr) exp_arr[fway][off] = exp_d;
    if (exp_done) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 8; i++)
          chk("array_contents", 32'(arr[w][i]), 32'(exp_arr[w][i]));
    end

    idle = !fill_valid || cyc > acc + flat + 9;
    if (miss && idle) begin
      fill_valid = 1'b1;
      acc        = cyc;
      flat       = lat;
      fblk       = maddr[15:4];
      fway       = vway;
    end
    cyc++;
  endtask

  task automatic fill(input logic [15:0] a, input logic w, input int l);
    lat = l;
    step(1'b1, a, w, 1'b0);
    repeat (l + 9) step(1'b0, a, w, 1'b0);
  endtask

  initial begin
    int a0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) begin
        arr[w][i]     = 16'h0;
        exp_arr[w][i] = 16'h0;
      end
    bus.miss_detected  = 1'b0;
    bus.miss_address   = 16'h0;
    bus.victim_way     = 1'b0;
    bus.mem_data       = 16'h0;
    bus.mem_data_valid = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk_quiet_outputs("reset");
    bus.miss_detected  = 1'b1;
    bus.miss_address   = 16'h5555;
    bus.mem_data_valid = 1'b1;
    bus.mem_data       = 16'h7777;
    @(negedge clk); #1;
    chk_quiet_outputs("reset_held");
    bus.miss_detected  = 1'b0;
    bus.mem_data_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc   = 0;

    // Basic fill, L=4, way 1
    seq_mode = 1'b0;
    seed     = 16'h5A5A;
    fill(16'h1234, 1'b1, 4);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    // Way 0 fill with sequential data, then read back from the array model
    seq_mode = 1'b1;
    fill(16'hA0F0, 1'b0, int'($urandom_range(1, 6)));
    for (int i = 0; i < 8; i++) chk("readback_way0", 32'(arr[0][i]), 32'h1000 + 32'(i));
    seq_mode = 1'b0;

    // Spurious valid while idle
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    // Busy lockout with miss held high and address changing mid-fill
    lat = 4;
    a0  = cyc;
    while (cyc <= a0 + 4 + 10)
      step(1'b1, (cyc - a0 >= 3) ? 16'hBEEF : 16'h1234, 1'b0, 1'b0);
    repeat (4 + 9) step(1'b0, 16'h0, 1'b0, 1'b0);

    // Mid-fill reset at cycle 7
    lat = 3;
    step(1'b1, 16'h4560, 1'b1, 1'b0);
    repeat (7) step(1'b0, 16'h4560, 1'b1, 1'b0);
    bus.mem_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_quiet_outputs("midfill_reset");
    fill_valid = 1'b0;
    rq.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    fill(16'h4560, 1'b1, 3);

    // Back-to-back misses, second asserted the cycle after DONE
    fill(16'h1100, 1'b0, 2);
    fill(16'h2000, 1'b1, 5);

    // Randomized fills with idle gaps and spurious valids
    repeat (6) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 16'($urandom), 1'($urandom), 1'($urandom));
      seed = 16'($urandom);
      fill(16'($urandom), 1'($urandom), int'($urandom_range(1, 6)));
    end
    repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
